// File: rtl/video_timing_pkg.sv
// Shared timing types and helpers for the raster timing generator.
// The optional colour-bar generator is enabled with TEST_PATTERN_EN.
package video_timing_pkg;

  typedef struct packed {
    int hdisp;
    int hfp;
    int hpulse;
    int hbp;
    int vdisp;
    int vfp;
    int vpulse;
    int vbp;
  } timing_t;

  function automatic int htotal(input timing_t t);
    return t.hdisp + t.hfp + t.hpulse + t.hbp;
  endfunction

  function automatic int vtotal(input timing_t t);
    return t.vdisp + t.vfp + t.vpulse + t.vbp;
  endfunction

  // Counter width that never collapses to zero bits for tiny sizes
  function automatic int clogb(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Colour bars left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/video_timing_gen_raster_counter.sv
// Horizontal/vertical raster position counter with a configurable start point.
module raster_counter #(
  parameter int HTOTAL = 8,
  parameter int VTOTAL = 5,
  parameter int HW     = 3,
  parameter int VW     = 3,
  parameter int H0     = 0,
  parameter int V0     = 0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] hc,
  output logic [VW-1:0] vc
);

  localparam logic [HW-1:0] HLAST = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] VLAST = VW'(VTOTAL - 1);

  // hc steps every cycle; vc steps on each hc wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      hc <= HW'(H0);
      vc <= VW'(V0);
    end else if (hc == HLAST) begin
      hc <= '0;
      vc <= (vc == VLAST) ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: sync/DE/coordinates plus a look-ahead fetch stream
// running LEAD cycles ahead. Optional colour bars under TEST_PATTERN_EN.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter int HS_POL = 0,
  parameter int VS_POL = 0,
  parameter int LEAD   = 4,
  parameter int FCW    = 16,
  localparam timing_t TP = '{hdisp: HDISP, hfp: HFP, hpulse: HPULSE, hbp: HBP,
                             vdisp: VDISP, vfp: VFP, vpulse: VPULSE, vbp: VBP},
  localparam int HTOTAL = htotal(TP),
  localparam int VTOTAL = vtotal(TP),
  localparam int HW  = clogb(HTOTAL),
  localparam int VW  = clogb(VTOTAL),
  localparam int FXW = clogb(HDISP),
  localparam int FYW = clogb(VDISP)
) (
  input  logic           pixel_clk,
  input  logic           pixel_rst,
  output logic           vid_hs,
  output logic           vid_vs,
  output logic           vid_de,
  output logic [HW-1:0]  vid_x,
  output logic [VW-1:0]  vid_y,
  output logic           vid_sof,
  output logic           vid_eol,
  output logic           fetch_req,
  output logic [FXW-1:0] fetch_x,
  output logic [FYW-1:0] fetch_y,
  output logic [FCW-1:0] frame_cnt
`ifdef TEST_PATTERN_EN
  ,
  output logic [7:0]     vid_r,
  output logic [7:0]     vid_g,
  output logic [7:0]     vid_b
`endif
);

  if (LEAD < 1 || LEAD >= HTOTAL) begin : g_bad_lead
    $error("video_timing_gen: LEAD must be in 1..HTOTAL-1");
  end
  if (HDISP < 1 || VDISP < 1) begin : g_bad_disp
    $error("video_timing_gen: HDISP and VDISP must be non-zero");
  end

  // Sync band end is inclusive so HBP=0 still fits in the counter width
  localparam logic [HW-1:0] H_DISP = HW'(HDISP);
  localparam logic [HW-1:0] H_EOL  = HW'(HDISP - 1);
  localparam logic [HW-1:0] H_SS   = HW'(HDISP + HFP);
  localparam logic [HW-1:0] H_SE   = HW'(HDISP + HFP + HPULSE - 1);
  localparam logic [VW-1:0] V_DISP = VW'(VDISP);
  localparam logic [VW-1:0] V_SS   = VW'(VDISP + VFP);
  localparam logic [VW-1:0] V_SE   = VW'(VDISP + VFP + VPULSE - 1);
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  logic [HW-1:0] hc, fhc;
  logic [VW-1:0] vc, fvc;
  logic          sof_seen;

  raster_counter #(.HTOTAL(HTOTAL), .VTOTAL(VTOTAL), .HW(HW), .VW(VW),
                   .H0(0), .V0(0)) u_disp (
    .clk(pixel_clk), .rst(pixel_rst), .hc(hc), .vc(vc)
  );

  // LEAD < HTOTAL, so the fetch start point is still on line 0
  raster_counter #(.HTOTAL(HTOTAL), .VTOTAL(VTOTAL), .HW(HW), .VW(VW),
                   .H0(LEAD), .V0(0)) u_fetch (
    .clk(pixel_clk), .rst(pixel_rst), .hc(fhc), .vc(fvc)
  );

  // Register all timing outputs one cycle behind the counters
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      vid_hs    <= ~HS_ACT;
      vid_vs    <= ~VS_ACT;
      vid_de    <= 1'b0;
      vid_x     <= '0;
      vid_y     <= '0;
      vid_sof   <= 1'b0;
      vid_eol   <= 1'b0;
      fetch_req <= 1'b0;
      fetch_x   <= '0;
      fetch_y   <= '0;
      frame_cnt <= '0;
      sof_seen  <= 1'b0;
    end else begin
      vid_hs    <= (hc >= H_SS && hc <= H_SE) ? HS_ACT : ~HS_ACT;
      vid_vs    <= (vc >= V_SS && vc <= V_SE) ? VS_ACT : ~VS_ACT;
      vid_de    <= (hc < H_DISP) && (vc < V_DISP);
      vid_x     <= hc;
      vid_y     <= vc;
      vid_sof   <= (hc == '0) && (vc == '0);
      vid_eol   <= (hc == H_EOL) && (vc < V_DISP);
      fetch_req <= (fhc < H_DISP) && (fvc < V_DISP);
      fetch_x   <= FXW'(fhc);
      fetch_y   <= FYW'(fvc);
      // The first frame after reset is not counted as completed
      if (hc == '0 && vc == '0) begin
        if (sof_seen) frame_cnt <= frame_cnt + 1'b1;
        sof_seen <= 1'b1;
      end
    end
  end

`ifdef TEST_PATTERN_EN
  logic [2:0] bar;

  // Bar index from the column about to be presented
  always_comb begin
    bar = 3'((int'(hc) * 8) / HDISP);
  end

  // Colours registered alongside vid_de, black outside the active area
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      {vid_r, vid_g, vid_b} <= '0;
    end else if (hc < H_DISP && vc < V_DISP) begin
      {vid_r, vid_g, vid_b} <= BAR_RGB[bar];
    end else begin
      {vid_r, vid_g, vid_b} <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: arithmetic reference model of the raster, directed
// reset/alignment steps followed by randomized reset bursts.
module tb_video_timing_gen;

  localparam int HD = 4, VD = 2, HF = 1, HP = 2, HB = 1, VF = 1, VP = 1, VB = 1;
  localparam int LEAD = 3;
  localparam int HT = HD + HF + HP + HB;
  localparam int VT = VD + VF + VP + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs, vs, de, sof, eol, freq;
  logic [2:0] x;
  logic [2:0] y;
  logic [1:0] fx;
  logic [0:0] fy;
  logic [15:0] fcnt;
`ifdef TEST_PATTERN_EN
  logic [7:0] r, g, b;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  int checks = 0;
  int errors = 0;
  int k = 0;            // non-reset edges since release
  int last_f = -1000;   // k of latest fetch (0,0)
  int last_sof = -1;

  video_timing_gen #(
    .HDISP(HD), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB),
    .VFP(VF), .VPULSE(VP), .VBP(VB), .HS_POL(0), .VS_POL(0),
    .LEAD(LEAD), .FCW(16)
  ) dut (
    .pixel_clk(clk), .pixel_rst(rst),
    .vid_hs(hs), .vid_vs(vs), .vid_de(de), .vid_x(x), .vid_y(y),
    .vid_sof(sof), .vid_eol(eol), .fetch_req(freq), .fetch_x(fx),
    .fetch_y(fy), .frame_cnt(fcnt)
`ifdef TEST_PATTERN_EN
    , .vid_r(r), .vid_g(g), .vid_b(b)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // Expected outputs from position arithmetic on the elapsed cycle count
  task automatic check_all();
    int p, h, v, fh, fv;
    bit e_de, e_fr;
    if (k == 0) begin
      chk("rst_hs", hs, 1); chk("rst_vs", vs, 1); chk("rst_de", de, 0);
      chk("rst_sof", sof, 0); chk("rst_eol", eol, 0); chk("rst_freq", freq, 0);
      chk("rst_x", x, 0); chk("rst_y", y, 0); chk("rst_fcnt", fcnt, 0);
`ifdef TEST_PATTERN_EN
      chk("rst_rgb", {r, g, b}, 0);
`endif
    end else begin
      p  = k - 1;
      h  = p % HT;
      v  = (p / HT) % VT;
      fh = (p + LEAD) % HT;
      fv = ((p + LEAD) / HT) % VT;
      e_de = (h < HD) && (v < VD);
      e_fr = (fh < HD) && (fv < VD);
      chk("hs", hs, (h >= HD + HF && h < HD + HF + HP) ? 0 : 1);
      chk("vs", vs, (v >= VD + VF && v < VD + VF + VP) ? 0 : 1);
      chk("de", de, e_de);
      chk("x", x, h);
      chk("y", y, v);
      chk("sof", sof, (h == 0 && v == 0));
      chk("eol", eol, (h == HD - 1 && v < VD));
      chk("freq", freq, e_fr);
      if (e_fr) begin
        chk("fetch_x", fx, fh);
        chk("fetch_y", fy, fv);
      end
      chk("fcnt", fcnt, (p / FRAME) % 65536);
`ifdef TEST_PATTERN_EN
      chk("rgb", {r, g, b}, e_de ? bars[(h * 8) / HD] : 24'h0);
`endif
    end
    // Cross-checks measured directly on the output streams
    if (freq && fx == 0 && fy == 0) last_f = k;
    if (de && x == 0 && y == 0 && k > 1) chk("lead", k - last_f, LEAD);
    if (sof) begin
      if (last_sof >= 0) chk("sof_period", k - last_sof, FRAME);
      last_sof = k;
    end
  endtask

  task automatic step();
    logic r_at_edge;
    r_at_edge = rst;
    @(posedge clk);
    #1;
    if (r_at_edge) begin
      k = 0;
      last_f = -1000;
      last_sof = -1;
    end else begin
      k++;
    end
    check_all();
  endtask

  initial begin
    // Power-up reset
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    // Three full frames: sof period, frame_cnt 1 then 2, fetch lead
    repeat (3 * FRAME + 5) step();
    chk("fcnt_after3", fcnt, 3);
    // Mid-frame abort: reset at cycle 17 for 2 cycles
    rst = 1'b1; repeat (3) step(); rst = 1'b0;
    repeat (17) step();
    rst = 1'b1; repeat (2) step();
    chk("abort_fcnt", fcnt, 0);
    rst = 1'b0;
    step();
    chk("resume_sof", sof, 1);
    repeat (2 * FRAME) step();
    // Randomized run lengths and reset bursts
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(120, 5)) step();
      rst = 1'b1;
      repeat ($urandom_range(3, 1)) step();
      rst = 1'b0;
    end
    repeat (FRAME + 3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator for the SoCFPGA video controller. It replaces fixed HDISP/VDISP timing with a full set of porch, pulse and polarity parameters.
- Produces HS/VS/DE plus pixel coordinates. It also produces a look-ahead fetch stream, LEAD cycles early, so the framebuffer reader can hide memory latency.
- Sits between the pixel clock domain and the video_if driver inside Top. The 160x90 simulation configuration is used with the screen model.

Parameters:
- HDISP, 800, visible pixels per line
- VDISP, 480, visible lines per frame
- HFP, 40, horizontal front porch (cycles)
- HPULSE, 48, horizontal sync width
- HBP, 40, horizontal back porch
- VFP, 13, vertical front porch (lines)
- VPULSE, 3, vertical sync width
- VBP, 29, vertical back porch
- HS_POL, 0, active level of vid_hs
- VS_POL, 0, active level of vid_vs
- LEAD, 4, fetch look-ahead in cycles; legal range 1..HTOTAL-1
- FCW, 16, frame counter width

Ports:
- pixel_clk  in  1  pixel clock
- pixel_rst  in  1  synchronous active-high reset
- vid_hs  out  1  horizontal sync
- vid_vs  out  1  vertical sync
- vid_de  out  1  high during visible pixels
- vid_x  out  $clog2(HTOTAL)  horizontal position of the current output cycle
- vid_y  out  $clog2(VTOTAL)  vertical position
- vid_sof  out  1  one-cycle pulse at (0,0)
- vid_eol  out  1  one-cycle pulse at x=HDISP-1 on visible lines
- fetch_req  out  1  high when the fetch position is visible
- fetch_x  out  $clog2(HDISP)  fetch column
- fetch_y  out  $clog2(VDISP)  fetch line
- frame_cnt  out  FCW  completed frames, wraps
- vid_r, vid_g, vid_b  out  8 each  test pattern colour; present only with TEST_PATTERN_EN

Behaviour:
- Derived sizes: HTOTAL=HDISP+HFP+HPULSE+HBP and VTOTAL=VDISP+VFP+VPULSE+VBP.
- Line order: visible [0,HDISP), then front porch, then sync [HDISP+HFP, HDISP+HFP+HPULSE), then back porch. Vertical order is the same, in lines.
- Counters hc and vc:
  - hc increments every cycle and wraps at HTOTAL-1 to 0.
  - vc increments when hc wraps, and wraps at VTOTAL-1 to 0.
- All outputs are registered, with 1-cycle latency from the counters. The output at cycle t+1 reflects the (hc,vc) value of cycle t.
- Output levels:
  - vid_hs = HS_POL while hc is in the sync band, otherwise !HS_POL.
  - vid_vs is the same scheme on vc, and is asserted for whole lines (aligned to hc=0).
  - vid_de = (hc<HDISP) && (vc<VDISP).
- Fetch counters (fhc, fvc) run the same wrap rules, but lead (hc,vc) by exactly LEAD cycles, including wrap across line and frame boundaries.
  - fetch_req = (fhc<HDISP) && (fvc<VDISP), with the same 1-cycle registration.
  - Therefore fetch_req rises exactly LEAD cycles before vid_de for the same (x,y).
- frame_cnt increments (mod 2^FCW) on the cycle vid_sof is asserted, except for the first vid_sof after reset.
- Reset:
  - hc=vc=0; fhc,fvc = the position LEAD cycles after (0,0).
  - Outputs: hs=!HS_POL, vs=!VS_POL, de=0, sof=0, eol=0, fetch_req=0, x=y=0, frame_cnt=0.
  - Reset asserted mid-frame aborts the frame. The first cycle after deassertion is (0,0), and vid_sof appears on the next cycle.
- Degenerate porches (HFP=0 or HBP=0) are legal; sync is then adjacent to the visible region. HPULSE and VPULSE are ≥1.
- Elaboration errors ($error) are raised for LEAD=0, LEAD≥HTOTAL, or zero HDISP/VDISP.

Optional Feature:
- Macro: TEST_PATTERN_EN.
- Defined:
  - vid_r/g/b ports exist.
  - 8 vertical colour bars of width HDISP/8, index = vid_x*8/HDISP, in the order white, yellow, cyan, green, magenta, red, blue, black.
  - Colours are registered aligned with vid_de and forced to 0 when de=0.
- Undefined: ports are absent; no logic is generated.

Decomposition:
- Package video_timing_pkg holds:
  - the timing-params struct and HTOTAL/VTOTAL helper functions;
  - the colour-bar constant array.
- Natural sub-module: raster_counter (hc/vc with wrap). It is instantiated twice, once for display and once for fetch, with a reset-start-position parameter.

Test Plan (HDISP=4,VDISP=2,HFP=1,HPULSE=2,HBP=1,VFP=1,VPULSE=1,VBP=1,LEAD=3; HTOTAL=8,VTOTAL=5):
- Release reset → vid_sof=1 on cycle 1, vid_de high cycles 1-4, vid_eol at cycle 4, vid_hs low at cycles 6-7 (HS_POL=0).
- Each frame is 40 cycles → vid_sof period is 40; frame_cnt reads 1 after the second vid_sof and 2 after the third.
- Fetch alignment → fetch_req with (fetch_x,fetch_y)=(0,0) exactly 3 cycles before vid_de with (vid_x,vid_y)=(0,0). Line 1 fetch appears during line 0 porch; frame wrap fetch (0,0) appears during the last back-porch line.
- vid_vs=0 exactly for vc=3 (cycles 25-32 after reset release); vid_de never high while vid_vs is active.
- Assert pixel_rst at cycle 17 for 2 cycles → all outputs equal their reset values, frame_cnt=0, sof resumes one cycle after release.
- With TEST_PATTERN_EN and HDISP=8 → vid_r/g/b at x=0 is FFFFFF, at x=1 is FFFF00, at x=7 is 000000; 0 during blanking.
